// File: rtl/router_pkt_src_if.sv
// Router input-port link: byte stream toward the router plus its
// busy back-pressure and parity-error flag.
interface router_pkt_src_if;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       busy;
    logic       err;

    modport master (
        output pkt_valid, pkt_data,
        input  busy, err
    );

    modport slave (
        input  pkt_valid, pkt_data,
        output busy, err
    );
endinterface

// File: rtl/router_pkt_src.sv
// Packet source for the router: buffered payload, header/payload/parity
// framing, router err window. ROUTER_PKT_SRC_ERR_INJ_EN adds inj_err.
module router_pkt_src #(
    parameter int DEPTH   = 64,
    parameter int ERR_WIN = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       buf_full,
    output logic       buf_empty,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
    input  logic       inj_err,
`endif
    output logic       ready,
    output logic       cfg_err,
    router_pkt_src_if.master rtr,
    output logic       done,
    output logic       err_seen
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (ERR_WIN < 2) ? 1 : $clog2(ERR_WIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PAY, S_PAR, S_ERRW, S_GAP
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, cnt_nx;
    logic [5:0]    len_q, len_d, rem_q, rem_d;
    logic [7:0]    par_q, par_d;
    logic [WW-1:0] win_q, win_d;
    logic          flag_q, flag_d;
    logic          inj_q, inj_d;
    logic          vld_q, vld_d;
    logic [7:0]    dat_q, dat_d;
    logic          cfg_d, done_d, seen_d;

    logic       start_ok, xfer, push, pop;
    logic [7:0] head, head_nx, hdr, last;

    assign start_ok = (dest_addr != 2'b11) && (pay_len != 6'd0)
                   && (count >= CW'(pay_len));
    assign xfer     = !rtr.busy;
    assign push     = wr_en && !buf_full;
    assign pop      = (state == S_PAY) && xfer;
    assign cnt_nx   = count + CW'(push) - CW'(pop);
    assign head     = mem[rd_ptr];
    assign head_nx  = mem[rd_ptr + AW'(1)];
    assign hdr      = {pay_len, dest_addr};
    // Injection flips only the transmitted parity, not the running XOR.
    assign last     = par_q ^ dat_q ^ {7'd0, inj_q};

`ifdef ROUTER_PKT_SRC_ERR_INJ_EN
    assign inj_d = (state == S_IDLE && start && start_ok) ? inj_err : inj_q;
`else
    assign inj_d = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (start && start_ok)       state_nx = S_HDR;
            S_HDR:  if (xfer)                    state_nx = S_PAY;
            S_PAY:  if (xfer && rem_q == 6'd1)   state_nx = S_PAR;
            S_PAR:  if (xfer)                    state_nx = S_ERRW;
            S_ERRW: if (win_q <= WW'(1))         state_nx = S_GAP;
            S_GAP:                               state_nx = S_IDLE;
            default:                             state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        cfg_d  = 1'b0;
        done_d = 1'b0;
        seen_d = 1'b0;
        len_d  = len_q;
        rem_d  = rem_q;
        par_d  = par_q;
        win_d  = win_q;
        flag_d = flag_q;
        unique case (state)
            S_IDLE: begin
                if (start && start_ok) begin
                    len_d = pay_len;
                    vld_d = 1'b1;
                    dat_d = hdr;
                    par_d = hdr;
                end else if (start) begin
                    cfg_d = 1'b1;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    dat_d = head;
                    rem_d = len_q;
                end
            end
            S_PAY: begin
                if (xfer) begin
                    par_d = par_q ^ dat_q;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        vld_d = 1'b0;
                        dat_d = last;
                    end else begin
                        dat_d = head_nx;
                    end
                end
            end
            S_PAR: begin
                if (xfer) begin
                    dat_d  = 8'd0;
                    win_d  = WW'(ERR_WIN);
                    flag_d = 1'b0;
                end
            end
            S_ERRW: begin
                flag_d = flag_q | rtr.err;
                if (win_q <= WW'(1)) begin
                    done_d = 1'b1;
                    seen_d = flag_q | rtr.err;
                end else begin
                    win_d = win_q - WW'(1);
                end
            end
            default: begin
                vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            buf_full  <= 1'b0;
            buf_empty <= 1'b1;
            ready     <= 1'b1;
            cfg_err   <= 1'b0;
            done      <= 1'b0;
            err_seen  <= 1'b0;
            vld_q     <= 1'b0;
            dat_q     <= 8'd0;
            len_q     <= '0;
            rem_q     <= '0;
            par_q     <= '0;
            win_q     <= '0;
            flag_q    <= 1'b0;
            inj_q     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= cnt_nx;
            buf_full  <= (cnt_nx == CW'(DEPTH));
            buf_empty <= (cnt_nx == '0);
            ready     <= (state_nx == S_IDLE);
            cfg_err   <= cfg_d;
            done      <= done_d;
            err_seen  <= seen_d;
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            par_q     <= par_d;
            win_q     <= win_d;
            flag_q    <= flag_d;
            inj_q     <= inj_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rtr.pkt_valid = vld_q;
    assign rtr.pkt_data  = dat_q;

endmodule
